// File: rtl/uart_receiver.sv
// uart_receiver: UART RX deserializer driven by the 16x oversampling tick.
// Supports 5-8 data bits, optional even/odd parity, 1 or 2 stop bits, and
// reports parity and framing errors per frame.
// Optional build macro: UART_RX_MAJORITY_EN makes every bit decision a 2-of-3
// majority of the synced line at ticks 6/7/8, decided at tick 8.
module uart_receiver #(
  parameter int unsigned OVS_RATE = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       ov_baud_rt_i,
  input  logic       rx_i,
  input  logic [1:0] data_width_i,
  input  logic       parity_en_i,
  input  logic       parity_odd_i,
  input  logic       stop_bits_i,
  output logic [7:0] rx_data_o,
  output logic       rx_done_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       rx_busy_o
);

  localparam int unsigned TW = $clog2(OVS_RATE);
  localparam logic [TW-1:0] T_LAST = TW'(OVS_RATE - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [TW-1:0] T_DECIDE = TW'(OVS_RATE / 2);
  localparam logic [TW-1:0] T_EARLY  = TW'(OVS_RATE / 2 - 2);
  localparam logic [TW-1:0] T_MID    = TW'(OVS_RATE / 2 - 1);
`else
  localparam logic [TW-1:0] T_DECIDE = TW'(OVS_RATE / 2 - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic            rx_meta, rx_s;
  logic [TW-1:0]   tcnt;
  logic [2:0]      bcnt;
  logic [1:0]      cfg_width;
  logic            cfg_pen, cfg_podd, cfg_stop2;
  logic [7:0]      shreg;
  logic            par_acc, pe_acc, fe_acc;
  logic            armed;
  logic            bit_val;
  logic            sample_pt, bit_end, start_det, last_bit, stop_low;

  // Two-flop synchronizer for the asynchronous RX line, idle-high reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic s_early, s_mid;

  // Capture the two samples preceding the decision tick
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s_early <= 1'b1;
      s_mid   <= 1'b1;
    end else if (ov_baud_rt_i) begin
      if (tcnt == T_EARLY) s_early <= rx_s;
      if (tcnt == T_MID)   s_mid   <= rx_s;
    end
  end

  assign bit_val = (s_early & s_mid) | (s_early & rx_s) | (s_mid & rx_s);
`else
  assign bit_val = rx_s;
`endif

  assign sample_pt = ov_baud_rt_i && (tcnt == T_DECIDE);
  assign bit_end   = ov_baud_rt_i && (tcnt == T_LAST);
  assign start_det = (state_q == IDLE) && !rx_s && armed;
  assign last_bit  = (bcnt == {1'b1, cfg_width});
  assign stop_low  = sample_pt && ((state_q == STOP1) || (state_q == STOP2)) && !bit_val;

  assign rx_done_o = (state_q == DONE);
  assign rx_busy_o = (state_q != IDLE) && (state_q != DONE);

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start_det) state_d = START;
      START: begin
        if (sample_pt && bit_val) state_d = IDLE;
        else if (bit_end)         state_d = DATA;
      end
      DATA:   if (bit_end && last_bit) state_d = cfg_pen ? PARITY : STOP1;
      PARITY: if (bit_end) state_d = STOP1;
      STOP1: begin
        if (sample_pt && !cfg_stop2) state_d = DONE;
        else if (bit_end && cfg_stop2) state_d = STOP2;
      end
      STOP2:  if (sample_pt) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tick counter restarts on start detection so bit centres line up with the start edge
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)          tcnt <= '0;
    else if (start_det)    tcnt <= '0;
    else if (ov_baud_rt_i) tcnt <= tcnt + 1'b1;
  end

  // Frame configuration is frozen at start detection
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cfg_width <= '0;
      cfg_pen   <= 1'b0;
      cfg_podd  <= 1'b0;
      cfg_stop2 <= 1'b0;
    end else if (start_det) begin
      cfg_width <= data_width_i;
      cfg_pen   <= parity_en_i;
      cfg_podd  <= parity_odd_i;
      cfg_stop2 <= stop_bits_i;
    end
  end

  // Bit counter, shift register and per-frame error accumulators
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bcnt    <= '0;
      shreg   <= '0;
      par_acc <= 1'b0;
      pe_acc  <= 1'b0;
      fe_acc  <= 1'b0;
    end else if (start_det) begin
      bcnt    <= '0;
      shreg   <= '0;
      par_acc <= 1'b0;
      pe_acc  <= 1'b0;
      fe_acc  <= 1'b0;
    end else begin
      if (state_q == START && bit_end) bcnt <= '0;
      else if (state_q == DATA && bit_end) bcnt <= bcnt + 1'b1;
      if (state_q == DATA && sample_pt) begin
        shreg   <= {bit_val, shreg[7:1]};
        par_acc <= par_acc ^ bit_val;
      end
      if (state_q == PARITY && sample_pt) pe_acc <= bit_val ^ par_acc ^ cfg_podd;
      if (state_q == STOP1 && sample_pt)  fe_acc <= !bit_val;
    end
  end

  // A low stop bit disarms start detection until the line has been seen high,
  // so a break is reported once instead of retriggering back-to-back frames.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)       armed <= 1'b0;
    else if (start_det) armed <= 1'b0;
    else if (stop_low)  armed <= 1'b0;
    else if (rx_s)      armed <= 1'b1;
  end

  // Result registers load on entry to DONE and hold until the next frame completes
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_data_o    <= '0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else if (state_d == DONE && state_q != DONE) begin
      rx_data_o    <= shreg >> (2'd3 - cfg_width);
      parity_err_o <= pe_acc;
      frame_err_o  <= fe_acc | !bit_val;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: table-driven, hand-sequenced and randomized checks of uart_receiver
// against a frame-level reference model.
module tb_uart_receiver;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       ov_baud_rt_i = 1'b0;
  logic       rx_i = 1'b1;
  logic [1:0] data_width_i = 2'd3;
  logic       parity_en_i = 1'b0;
  logic       parity_odd_i = 1'b0;
  logic       stop_bits_i = 1'b0;
  logic [7:0] rx_data_o;
  logic       rx_done_o, parity_err_o, frame_err_o, rx_busy_o;

  int errors = 0;
  int checks = 0;

`ifdef UART_RX_MAJORITY_EN
  localparam int         MAJ_DLY    = 40;
  localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
  localparam int         MAJ_DLY    = 0;
  localparam logic [7:0] GLITCH_EXP = 8'h08;
`endif

  uart_receiver #(.OVS_RATE(16)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .ov_baud_rt_i (ov_baud_rt_i),
    .rx_i         (rx_i),
    .data_width_i (data_width_i),
    .parity_en_i  (parity_en_i),
    .parity_odd_i (parity_odd_i),
    .stop_bits_i  (stop_bits_i),
    .rx_data_o    (rx_data_o),
    .rx_done_o    (rx_done_o),
    .parity_err_o (parity_err_o),
    .frame_err_o  (frame_err_o),
    .rx_busy_o    (rx_busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Oversampling tick: one clk high every 4 clk, changed on the falling edge
  initial begin : ov_gen
    int div;
    div = 0;
    forever begin
      @(negedge clk_i);
      ov_baud_rt_i = (div == 0);
      div = (div + 1) % 4;
    end
  end

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    time        t;
  } rec_t;

  rec_t rbuf[256];
  int   done_cnt = 0;

  // Record every done pulse with its outputs and time
  always @(negedge clk_i) begin
    if (rx_done_o === 1'b1) begin
      rbuf[done_cnt % 256] = '{rx_data_o, parity_err_o, frame_err_o, $time};
      done_cnt = done_cnt + 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk_i); while (ov_baud_rt_i !== 1'b1);
    end
    #1;
  endtask

  // Start edge to observed done: the last stop bit is sampled at its centre
  function automatic int latency(input logic [1:0] w, input logic pen, input logic st2);
    int k;
    k = 1 + (5 + int'(w)) + int'(pen) + int'(st2);
    return 10 * (32 + 64 * k) + 4 + MAJ_DLY;
  endfunction

  // Reference model of one frame's outcome
  task automatic model(input logic [7:0] d, input logic [1:0] w, input logic pen, input logic podd,
                       input logic st2, input logic pb, input logic s1, input logic s2,
                       output logic [7:0] ed, output logic epe, output logic efe);
    int n, ones;
    logic good_pb;
    n = 5 + int'(w);
    ones = 0;
    ed = 8'h00;
    for (int i = 0; i < n; i++) begin
      ed[i] = d[i];
      ones += int'(d[i]);
    end
    good_pb = logic'(ones % 2) ^ podd;
    epe = pen && (pb != good_pb);
    efe = !s1 || (st2 && !s2);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] w, input logic pen,
                            input logic podd, input logic st2, input logic pb, input logic s1,
                            input logic s2, input int gap, input int glitch, input int tail_low,
                            input bit scramble, output time ts);
    data_width_i = w;
    parity_en_i  = pen;
    parity_odd_i = podd;
    stop_bits_i  = st2;
    rx_i = 1'b0;
    ts = $time;
    wait_ticks(16);
    if (scramble) {data_width_i, parity_en_i, parity_odd_i, stop_bits_i} = 5'($urandom);
    for (int i = 0; i < 5 + int'(w); i++) begin
      rx_i = d[i];
      if (i == glitch) begin
        wait_ticks(7);
        rx_i = ~d[i];
        wait_ticks(1);
        rx_i = d[i];
        wait_ticks(8);
      end else begin
        wait_ticks(16);
      end
    end
    if (pen) begin
      rx_i = pb;
      wait_ticks(16);
    end
    rx_i = s1;
    wait_ticks(16);
    if (st2) begin
      rx_i = s2;
      wait_ticks(16);
    end
    if (tail_low > 0) begin
      rx_i = 1'b0;
      wait_ticks(tail_low);
    end
    rx_i = 1'b1;
    if (gap > 0) wait_ticks(gap);
  endtask

  task automatic expect_frame(input string nm, input int idx, input logic [7:0] ed,
                              input logic epe, input logic efe, input time ts, input int lat);
    int waited;
    rec_t r;
    waited = 0;
    while (done_cnt <= idx && waited < 2000) begin
      @(posedge clk_i);
      waited++;
    end
    if (done_cnt <= idx) begin
      checks++;
      errors++;
      $display("FAIL %s.timeout: no rx_done_o within %0d clk", nm, waited);
    end else begin
      r = rbuf[idx % 256];
      check({nm, ".data"}, 32'(r.d), 32'(ed));
      check({nm, ".parity_err"}, 32'(r.pe), 32'(epe));
      check({nm, ".frame_err"}, 32'(r.fe), 32'(efe));
      check({nm, ".latency"}, 32'(r.t - ts), 32'(lat));
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic [1:0] w;
    logic       pen, podd, st2, pb, s1, s2;
    logic [7:0] ed;
    logic       epe, efe;
  } vec_t;

  initial begin : main
    vec_t tbl[9];
    time  ts;
    int   base;
    logic [7:0] ed;
    logic epe, efe;

    //            d      w     pen   podd  st2   pb    s1    s2    exp_d  pe    fe
    tbl[0] = '{8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h35, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h35, 1'b0, 1'b0};
    tbl[2] = '{8'h35, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h35, 1'b1, 1'b0};
    tbl[3] = '{8'h1F, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1F, 1'b0, 1'b1};
    tbl[4] = '{8'h2A, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h2A, 1'b0, 1'b1};
    tbl[5] = '{8'h00, 2'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[6] = '{8'hFF, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h1F, 1'b0, 1'b0};
    tbl[7] = '{8'h81, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h81, 1'b1, 1'b1};
    tbl[8] = '{8'h1A, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h1A, 1'b0, 1'b1};

    // Reset values
    #23;
    check("reset.rx_data", 32'(rx_data_o), 32'h0);
    check("reset.rx_done", 32'(rx_done_o), 32'h0);
    check("reset.parity_err", 32'(parity_err_o), 32'h0);
    check("reset.frame_err", 32'(frame_err_o), 32'h0);
    check("reset.rx_busy", 32'(rx_busy_o), 32'h0);
    rst_n_i = 1'b1;
    wait_ticks(3);

    // Table-driven frames
    for (int v = 0; v < 9; v++) begin
      base = done_cnt;
      send_frame(tbl[v].d, tbl[v].w, tbl[v].pen, tbl[v].podd, tbl[v].st2, tbl[v].pb,
                 tbl[v].s1, tbl[v].s2, 4, -1, 0, 1'b1, ts);
      expect_frame($sformatf("tbl%0d", v), base, tbl[v].ed, tbl[v].epe, tbl[v].efe, ts,
                   latency(tbl[v].w, tbl[v].pen, tbl[v].st2));
      check($sformatf("tbl%0d.count", v), 32'(done_cnt - base), 32'd1);
      check($sformatf("tbl%0d.busy_after", v), 32'(rx_busy_o), 32'h0);
    end

    // Short low pulse on the line: rejected as a false start
    base = done_cnt;
    rx_i = 1'b0;
    wait_ticks(3);
    check("glitch.busy_high", 32'(rx_busy_o), 32'h1);
    wait_ticks(2);
    rx_i = 1'b1;
    wait_ticks(40);
    check("glitch.no_done", 32'(done_cnt - base), 32'd0);
    check("glitch.busy_low", 32'(rx_busy_o), 32'h0);
    send_frame(8'h5C, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2, -1, 0, 1'b0, ts);
    expect_frame("after_glitch", base, 8'h5C, 1'b0, 1'b0, ts, latency(2'd3, 1'b0, 1'b0));

    // Break: all-zero data, low stop bit, line held low afterwards
    base = done_cnt;
    send_frame(8'h00, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4, -1, 40, 1'b0, ts);
    expect_frame("break", base, 8'h00, 1'b0, 1'b1, ts, latency(2'd3, 1'b0, 1'b0));
    wait_ticks(180);
    check("break.single_done", 32'(done_cnt - base), 32'd1);
    check("break.busy_low", 32'(rx_busy_o), 32'h0);

    // Single-tick glitch at the centre of data bit 3
    base = done_cnt;
    send_frame(8'h00, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2, 3, 0, 1'b0, ts);
    expect_frame("centre_glitch", base, GLITCH_EXP, 1'b0, 1'b0, ts, latency(2'd3, 1'b0, 1'b0));

    // Back-to-back frames with no idle gap, then reset during a third
    base = done_cnt;
    send_frame(8'h00, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, -1, 0, 1'b0, ts);
    expect_frame("b2b0", base, 8'h00, 1'b0, 1'b0, ts, latency(2'd3, 1'b0, 1'b0));
    send_frame(8'hFF, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, -1, 0, 1'b0, ts);
    expect_frame("b2b1", base + 1, 8'hFF, 1'b0, 1'b0, ts, latency(2'd3, 1'b0, 1'b0));
    rx_i = 1'b0;
    wait_ticks(16);
    rx_i = 1'b1;
    wait_ticks(16);
    rx_i = 1'b0;
    wait_ticks(8);
    check("midreset.busy_before", 32'(rx_busy_o), 32'h1);
    rst_n_i = 1'b0;
    #12;
    check("midreset.rx_data", 32'(rx_data_o), 32'h0);
    check("midreset.rx_done", 32'(rx_done_o), 32'h0);
    check("midreset.parity_err", 32'(parity_err_o), 32'h0);
    check("midreset.frame_err", 32'(frame_err_o), 32'h0);
    check("midreset.rx_busy", 32'(rx_busy_o), 32'h0);
    rx_i = 1'b1;
    #20;
    rst_n_i = 1'b1;
    wait_ticks(200);
    check("midreset.done_count", 32'(done_cnt - base), 32'd2);
    check("midreset.data_after", 32'(rx_data_o), 32'h0);
    check("midreset.busy_after", 32'(rx_busy_o), 32'h0);

    // Randomized frames against the reference model
    for (int n = 0; n < 25; n++) begin
      logic [7:0] d;
      logic [1:0] w;
      logic pen, podd, st2, pb, s1, s2, last_stop;
      int gap;
      d    = 8'($urandom);
      w    = 2'($urandom_range(0, 3));
      pen  = 1'($urandom);
      podd = 1'($urandom);
      st2  = 1'($urandom);
      pb   = 1'($urandom);
      s1   = ($urandom_range(0, 5) != 0);
      s2   = ($urandom_range(0, 5) != 0);
      last_stop = st2 ? s2 : s1;
      gap  = last_stop ? int'($urandom_range(0, 3)) : int'($urandom_range(2, 4));
      model(d, w, pen, podd, st2, pb, s1, s2, ed, epe, efe);
      base = done_cnt;
      send_frame(d, w, pen, podd, st2, pb, s1, s2, gap, -1, 0, 1'b1, ts);
      expect_frame($sformatf("rnd%0d", n), base, ed, epe, efe, ts, latency(w, pen, st2));
      check($sformatf("rnd%0d.count", n), 32'(done_cnt - base), 32'd1);
    end

    wait_ticks(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
